// File: rtl/reversi_move_engine_if.sv
// Request/response bundle for reversi_move_engine. The flip-stream signals exist
// only when REVERSI_FLIP_APPLY_EN is defined.
interface reversi_move_engine_if #(
  parameter int BOARD_N = 8,
  parameter int COORD_W = 3
);
  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int CNT_W = $clog2(CELLS) + 1;

  logic                 start;
  logic [1:0]           colour;
  logic [COORD_W-1:0]   x;
  logic [COORD_W-1:0]   y;
  logic [2*CELLS-1:0]   board_in;
  logic                 busy;
  logic                 done;
  logic                 valid_move;
  logic [CELLS-1:0]     flip_mask;
  logic [CNT_W-1:0]     flip_count;
`ifdef REVERSI_FLIP_APPLY_EN
  logic [2*CELLS-1:0]   board_out;
  logic [COORD_W-1:0]   flip_x;
  logic [COORD_W-1:0]   flip_y;
  logic                 flip_valid;
  logic                 flip_ready;

  modport master (output start, colour, x, y, board_in, flip_ready,
                  input  busy, done, valid_move, flip_mask, flip_count,
                         board_out, flip_x, flip_y, flip_valid);
  modport slave  (input  start, colour, x, y, board_in, flip_ready,
                  output busy, done, valid_move, flip_mask, flip_count,
                         board_out, flip_x, flip_y, flip_valid);
`else
  modport master (output start, colour, x, y, board_in,
                  input  busy, done, valid_move, flip_mask, flip_count);
  modport slave  (input  start, colour, x, y, board_in,
                  output busy, done, valid_move, flip_mask, flip_count);
`endif
endinterface

// File: rtl/reversi_move_engine.sv
// Reversi move legality / flip-mask engine, one board cell examined per cycle.
// Optional board update and flipped-cell stream: define REVERSI_FLIP_APPLY_EN.
module reversi_move_engine #(
  parameter int BOARD_N = 8,
  parameter int COORD_W = 3
) (
  input logic                  clk,
  input logic                  resetn,
  reversi_move_engine_if.slave bus
);
  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int IDX_W = $clog2(CELLS);
  localparam int CNT_W = IDX_W + 1;
  localparam int PW    = COORD_W + 2;

  typedef logic signed [PW-1:0] pos_t;
  localparam pos_t BN = pos_t'(BOARD_N);

`ifdef REVERSI_FLIP_APPLY_EN
  typedef enum logic [2:0] {IDLE, CHECK, SCAN, COMMIT, APPLY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CHECK, SCAN, COMMIT, DONE} state_t;
`endif

  state_t               state_q, state_d;
  logic [1:0]           colour_q, colour_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [2*CELLS-1:0]   board_q, board_d;
  logic [2:0]           dir_q, dir_d;
  pos_t                 px_q, px_d, py_q, py_d;
  logic [CELLS-1:0]     pending_q, pending_d;
  logic [CELLS-1:0]     flip_mask_q, mask_d;
  logic [CNT_W-1:0]     flip_count_q, count_d;
  logic                 valid_q, valid_d;

  function automatic logic [CNT_W-1:0] popcount(input logic [CELLS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < CELLS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Unit step for the current direction, N first, clockwise.
  logic signed [1:0] dx, dy;
  always_comb begin
    dx = 2'sd0;
    dy = 2'sd0;
    case (dir_q)
      3'd0: begin dx =  2'sd0; dy = -2'sd1; end
      3'd1: begin dx =  2'sd1; dy = -2'sd1; end
      3'd2: begin dx =  2'sd1; dy =  2'sd0; end
      3'd3: begin dx =  2'sd1; dy =  2'sd1; end
      3'd4: begin dx =  2'sd0; dy =  2'sd1; end
      3'd5: begin dx = -2'sd1; dy =  2'sd1; end
      3'd6: begin dx = -2'sd1; dy =  2'sd0; end
      default: begin dx = -2'sd1; dy = -2'sd1; end
    endcase
  end

  pos_t             nx, ny, tx, ty;
  logic             n_in, t_in, is_own, is_opp, t_occ, colour_ok;
  logic [IDX_W-1:0] nidx, tidx;
  logic [1:0]       ncell, tcell;
  logic [CELLS-1:0] nbit;

  assign nx    = px_q + pos_t'(dx);
  assign ny    = py_q + pos_t'(dy);
  assign n_in  = !nx[PW-1] && !ny[PW-1] && (nx < BN) && (ny < BN);
  assign nidx  = IDX_W'(ny[COORD_W-1:0]) * IDX_W'(BOARD_N) + IDX_W'(nx[COORD_W-1:0]);
  // Guard the select so an off-board step never reads beyond board_q.
  assign ncell = n_in ? board_q[{nidx, 1'b0} +: 2] : 2'b00;
  assign nbit  = {{(CELLS-1){1'b0}}, 1'b1} << nidx;
  assign is_own = n_in && (ncell == colour_q);
  assign is_opp = n_in && (ncell == (colour_q ^ 2'b11));

  assign tx        = pos_t'(x_q);
  assign ty        = pos_t'(y_q);
  assign t_in      = (tx < BN) && (ty < BN);
  assign tidx      = IDX_W'(y_q) * IDX_W'(BOARD_N) + IDX_W'(x_q);
  assign tcell     = t_in ? board_q[{tidx, 1'b0} +: 2] : 2'b00;
  assign t_occ     = (tcell == 2'b01) || (tcell == 2'b10);
  assign colour_ok = (colour_q == 2'b01) || (colour_q == 2'b10);

`ifdef REVERSI_FLIP_APPLY_EN
  logic [CELLS-1:0]   remain_q, remain_d, lo_bit, t_bit;
  logic               sent_q, sent_d;
  logic [2*CELLS-1:0] board_out_q, board_out_d, applied;
  logic [COORD_W-1:0] lo_x, lo_y;

  assign t_bit = {{(CELLS-1){1'b0}}, 1'b1} << tidx;

  // Lowest pending flipped cell, so the stream runs in ascending index order.
  always_comb begin
    lo_bit = '0;
    lo_x   = '0;
    lo_y   = '0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (remain_q[i]) begin
        lo_bit    = '0;
        lo_bit[i] = 1'b1;
        lo_x      = COORD_W'(i % BOARD_N);
        lo_y      = COORD_W'(i / BOARD_N);
      end
    end
  end

  always_comb begin
    applied = board_q;
    for (int i = 0; i < CELLS; i++)
      if (flip_mask_q[i] || t_bit[i]) applied[2*i +: 2] = colour_q;
  end

  assign bus.flip_valid = (state_q == APPLY);
  assign bus.flip_x     = (state_q != APPLY) ? '0 : (sent_q ? lo_x : x_q);
  assign bus.flip_y     = (state_q != APPLY) ? '0 : (sent_q ? lo_y : y_q);
  assign bus.board_out  = board_out_q;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    state_d   = state_q;
    colour_d  = colour_q;
    x_d       = x_q;
    y_d       = y_q;
    board_d   = board_q;
    dir_d     = dir_q;
    px_d      = px_q;
    py_d      = py_q;
    pending_d = pending_q;
    mask_d    = flip_mask_q;
    count_d   = flip_count_q;
    valid_d   = valid_q;
`ifdef REVERSI_FLIP_APPLY_EN
    remain_d    = remain_q;
    sent_d      = sent_q;
    board_out_d = board_out_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        colour_d = bus.colour;
        x_d      = bus.x;
        y_d      = bus.y;
        board_d  = bus.board_in;
        mask_d   = '0;
        count_d  = '0;
        valid_d  = 1'b0;
        state_d  = CHECK;
      end
      CHECK: if (!t_in || t_occ || !colour_ok) begin
`ifdef REVERSI_FLIP_APPLY_EN
        board_out_d = board_q;
`endif
        state_d = DONE;
      end else begin
        dir_d     = '0;
        px_d      = tx;
        py_d      = ty;
        pending_d = '0;
        state_d   = SCAN;
      end
      SCAN: if (is_opp) begin
        pending_d = pending_q | nbit;
        px_d      = nx;
        py_d      = ny;
      end else begin
        // A ray only counts when it closes on the mover's own colour.
        if (is_own) mask_d = flip_mask_q | pending_q;
        pending_d = '0;
        px_d      = tx;
        py_d      = ty;
        dir_d     = dir_q + 3'd1;
        if (dir_q == 3'd7) state_d = COMMIT;
      end
      COMMIT: begin
        count_d = popcount(flip_mask_q);
        valid_d = |flip_mask_q;
`ifdef REVERSI_FLIP_APPLY_EN
        remain_d = flip_mask_q;
        sent_d   = 1'b0;
        if (|flip_mask_q) begin
          state_d = APPLY;
        end else begin
          board_out_d = board_q;
          state_d     = DONE;
        end
`else
        state_d = DONE;
`endif
      end
`ifdef REVERSI_FLIP_APPLY_EN
      APPLY: if (bus.flip_ready) begin
        if (!sent_q) sent_d = 1'b1;
        else         remain_d = remain_q & ~lo_bit;
        if (sent_q && ((remain_q & ~lo_bit) == '0)) begin
          board_out_d = applied;
          state_d     = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= IDLE;
      colour_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      board_q      <= '0;
      dir_q        <= '0;
      px_q         <= '0;
      py_q         <= '0;
      pending_q    <= '0;
      flip_mask_q  <= '0;
      flip_count_q <= '0;
      valid_q      <= 1'b0;
`ifdef REVERSI_FLIP_APPLY_EN
      remain_q    <= '0;
      sent_q      <= 1'b0;
      board_out_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q      <= state_d;
      colour_q     <= colour_d;
      x_q          <= x_d;
      y_q          <= y_d;
      board_q      <= board_d;
      dir_q        <= dir_d;
      px_q         <= px_d;
      py_q         <= py_d;
      pending_q    <= pending_d;
      flip_mask_q  <= mask_d;
      flip_count_q <= count_d;
      valid_q      <= valid_d;
`ifdef REVERSI_FLIP_APPLY_EN
      remain_q    <= remain_d;
      sent_q      <= sent_d;
      board_out_q <= board_out_d;
`endif
    end
  end

  assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
  assign bus.done       = (state_q == DONE);
  assign bus.valid_move = valid_q;
  assign bus.flip_mask  = flip_mask_q;
  assign bus.flip_count = flip_count_q;
endmodule

// File: doc/reversi_move_engine.md
REVERSI_MOVE_ENGINE -- requirements
Module: reversi_move_engine

Interface
REQ-001 SHALL provide parameter BOARD_N, default 8: board edge length in cells, even, 4..16.
REQ-002 SHALL provide parameter COORD_W, default 3: coordinate width, equal to ceil(log2(BOARD_N)).
REQ-003 SHALL provide port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL provide port resetn  input  1  asynchronous, active-high reset; the port keeps the codebase name resetn.
REQ-005 SHALL provide port start  input  1  one-cycle request to evaluate a move.
REQ-006 SHALL provide port colour  input  2  mover: 01 black, 10 white.
REQ-007 SHALL provide ports x, y  input  COORD_W each  target cell.
REQ-008 SHALL provide port board_in  input  2*BOARD_N*BOARD_N  cell i=y*BOARD_N+x at bits [2i+1:2i]; 00 empty, 01 black, 10 white, 11 read as empty.
REQ-009 SHALL provide port busy  output  1  high from start acceptance through done.
REQ-010 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-011 SHALL provide port valid_move  output  1  target legal for colour.
REQ-012 SHALL provide port flip_mask  output  BOARD_N*BOARD_N  bit i set if cell i flips.
REQ-013 SHALL provide port flip_count  output  ceil(log2(BOARD_N*BOARD_N))+1  number of set bits in flip_mask.

Function
REQ-014 SHALL use FSM states IDLE, CHECK, SCAN, COMMIT, DONE (APPLY added per REQ-027).
REQ-015 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-016 SHALL latch colour, x, y and board_in on acceptance; later input changes SHALL not affect the evaluation.
REQ-017 SHALL in CHECK go directly to DONE with valid_move=0, flip_count=0 if target occupied, x or y >= BOARD_N, or colour is 00/11.
REQ-018 SHALL scan directions in order N, NE, E, SE, S, SW, W, NW, examining one cell per cycle from the target's neighbour outward.
REQ-019 SHALL accumulate opponent cells into a per-direction pending mask; on own colour with pending non-empty, pending SHALL be OR-ed into flip_mask; on empty, out-of-bounds, or own colour with pending empty, pending SHALL be discarded.
REQ-020 SHALL spend exactly one cycle on a direction whose first step leaves the board.
REQ-021 SHALL set valid_move=1 iff flip_count>0 after all eight directions (COMMIT).
REQ-022 SHALL pulse done for exactly one cycle, drop busy the same cycle, and hold valid_move, flip_mask, flip_count stable until the next accepted start.
REQ-023 SHALL clear flip_mask, flip_count and valid_move on acceptance of a new start.

Reset
REQ-024 SHALL on resetn high, asynchronously and at any state including mid-scan, force IDLE and busy=0, done=0, valid_move=0, flip_mask=0, flip_count=0 (and all REQ-027 outputs to 0).
REQ-025 SHALL accept a start on the first rising edge after resetn deasserts.

Configuration
REQ-026 SHALL compile the apply/stream feature only when macro REVERSI_FLIP_APPLY_EN is defined; otherwise the REQ-027 ports and APPLY state SHALL not exist and COMMIT SHALL go to DONE.
REQ-027 SHALL, with REVERSI_FLIP_APPLY_EN, add outputs board_out (2*BOARD_N*BOARD_N), flip_x, flip_y (COORD_W), flip_valid (1), input flip_ready (1); on valid move, APPLY SHALL stream the target then each flipped cell in ascending index, one per flip_valid&flip_ready transfer, holding flip_x/flip_y stable while flip_ready is low; board_out SHALL equal board_in with target and flipped cells set to colour, updated in the DONE cycle; on invalid move no transfer occurs and board_out is unchanged.

Verification
REQ-028 SHALL verify: 8x8 opening (white cells 27,36; black 28,35), black at x=2,y=3 -> valid_move=1, flip_count=1, flip_mask only bit 27.
REQ-029 SHALL verify: same board, black at x=3,y=3 (occupied) -> done 2 cycles after start, valid_move=0, flip_count=0.
REQ-030 SHALL verify: empty board, white at x=0,y=0 -> valid_move=0, flip_mask=0, no out-of-range access.
REQ-031 SHALL verify: start pulsed while busy ignored; resetn high mid-SCAN -> busy=0, all outputs 0 asynchronously, next start after release evaluates normally.
REQ-032 SHALL verify: BOARD_N=4, black at x=0,y=0, white at cells 1,5 and black at cells 2,10 -> flip_count=2, flip_mask bits 1 and 5.
REQ-033 SHALL verify: REVERSI_FLIP_APPLY_EN, REQ-028 stimulus, flip_ready low 3 cycles -> flip_x=2,flip_y=3 held stable, then transfers (2,3),(3,3), board_out cells 26,27 = 01.
